// File: rtl/therm_dwa_dec.sv
// Binary-to-thermometer decoder with data-weighted-averaging rotation for a
// 2**N_BITS-element unary DAC. tout, tout_vld and ptr are all registered.
module therm_dwa_dec #(
  parameter int unsigned N_BITS  = 6,
  parameter int unsigned PTR_RST = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BITS-1:0]          din,
  input  logic                       din_vld,
  input  logic                       dwa_en,
  input  logic                       ptr_clr,
  output logic [(1 << N_BITS)-1:0]   tout,
  output logic                       tout_vld,
  output logic [N_BITS-1:0]          ptr
);

  localparam int unsigned N_ELEM = 1 << N_BITS;
  localparam logic [N_ELEM-1:0] ONES = '1;
  localparam logic [N_BITS-1:0] PTR_RST_V = PTR_RST[N_BITS-1:0];

  logic [N_ELEM-1:0] tout_q, tout_d;
  logic              tout_vld_q, tout_vld_d;
  logic [N_BITS-1:0] ptr_q, ptr_d;
  logic [N_BITS-1:0] start;
  logic [N_ELEM-1:0] rot [N_BITS+1];

  always_comb begin
    start = (dwa_en && !ptr_clr) ? ptr_q : '0;

    // Thermometer mask from bit 0, then log2 barrel rotate-left by start.
    rot[0] = ~(ONES << din);
    for (int unsigned j = 0; j < N_BITS; j++) begin
      rot[j+1] = start[j] ? ((rot[j] << (1 << j)) | (rot[j] >> (N_ELEM - (1 << j))))
                          : rot[j];
    end

    tout_d     = tout_q;
    tout_vld_d = 1'b0;
    ptr_d      = ptr_clr ? '0 : ptr_q;
    if (din_vld) begin
      tout_d     = rot[N_BITS];
      tout_vld_d = 1'b1;
      ptr_d      = start + din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tout_q     <= '0;
      tout_vld_q <= 1'b0;
      ptr_q      <= PTR_RST_V;
    end else begin
      tout_q     <= tout_d;
      tout_vld_q <= tout_vld_d;
      ptr_q      <= ptr_d;
    end
  end

  assign tout     = tout_q;
  assign tout_vld = tout_vld_q;
  assign ptr      = ptr_q;

endmodule

// File: tb/tb_therm_dwa_dec.sv
// Directed and model-checked bench for therm_dwa_dec (64-element default).
module tb_therm_dwa_dec;

  logic        clk;
  logic        rst;
  logic [5:0]  din;
  logic        din_vld;
  logic        dwa_en;
  logic        ptr_clr;
  logic [63:0] tout;
  logic        tout_vld;
  logic [5:0]  ptr;

  int errors = 0;
  int checks = 0;

  therm_dwa_dec #(.N_BITS(6), .PTR_RST(0)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .dwa_en(dwa_en),
    .ptr_clr(ptr_clr), .tout(tout), .tout_vld(tout_vld), .ptr(ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic v, input logic [5:0] d,
                       input logic en, input logic clr);
    rst = r; din_vld = v; din = d; dwa_en = en; ptr_clr = clr;
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b1, 6'd20, 1'b1, 1'b0);
      checks++;
      if (tout !== 64'h0) begin errors++; $display("FAIL reset_tout cyc%0d got=%h exp=0", i, tout); end
      checks++;
      if (tout_vld !== 1'b0) begin errors++; $display("FAIL reset_vld cyc%0d got=%b exp=0", i, tout_vld); end
      checks++;
      if (ptr !== 6'd0) begin errors++; $display("FAIL reset_ptr cyc%0d got=%0d exp=0", i, ptr); end
    end
    apply(1'b0, 1'b1, 6'd20, 1'b1, 1'b0);
    checks++;
    if (tout !== 64'h0000_0000_000F_FFFF) begin errors++; $display("FAIL first_tout got=%h exp=%h", tout, 64'h0000_0000_000F_FFFF); end
    checks++;
    if (tout_vld !== 1'b1 || ptr !== 6'd20) begin errors++; $display("FAIL first_vld_ptr got=%b/%0d exp=1/20", tout_vld, ptr); end
  endtask

  task automatic test_plain();
    logic [5:0]  dins [4];
    logic [63:0] exps [4];
    dins = '{6'd0, 6'd1, 6'd32, 6'd63};
    exps = '{64'h0, 64'h1, 64'h0000_0000_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, dins[i], 1'b0, 1'b0);
      checks++;
      if (tout !== exps[i]) begin errors++; $display("FAIL plain_tout din=%0d got=%h exp=%h", dins[i], tout, exps[i]); end
      checks++;
      if (tout_vld !== 1'b1 || ptr !== dins[i]) begin errors++; $display("FAIL plain_vld_ptr din=%0d got=%b/%0d exp=1/%0d", dins[i], tout_vld, ptr, dins[i]); end
    end
  endtask

  task automatic test_dwa_wrap();
    logic [5:0]  dins [3];
    logic [63:0] exps [3];
    logic [5:0]  ptrs [3];
    dins = '{6'd10, 6'd50, 6'd10};
    exps = '{64'h0000_0000_0000_03FF, 64'h0FFF_FFFF_FFFF_FC00, 64'hF000_0000_0000_003F};
    ptrs = '{6'd10, 6'd60, 6'd6};
    apply(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, dins[i], 1'b1, 1'b0);
      checks++;
      if (tout !== exps[i]) begin errors++; $display("FAIL dwa_tout step%0d got=%h exp=%h", i, tout, exps[i]); end
      checks++;
      if (tout_vld !== 1'b1 || ptr !== ptrs[i]) begin errors++; $display("FAIL dwa_vld_ptr step%0d got=%b/%0d exp=1/%0d", i, tout_vld, ptr, ptrs[i]); end
    end
  endtask

  task automatic test_hold_clear();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 6'd33, 1'b1, 1'b0);
      checks++;
      if (tout !== 64'hF000_0000_0000_003F) begin errors++; $display("FAIL hold_tout cyc%0d got=%h exp=%h", i, tout, 64'hF000_0000_0000_003F); end
      checks++;
      if (tout_vld !== 1'b0 || ptr !== 6'd6) begin errors++; $display("FAIL hold_vld_ptr cyc%0d got=%b/%0d exp=0/6", i, tout_vld, ptr); end
    end
    apply(1'b0, 1'b0, 6'd0, 1'b1, 1'b1);
    checks++;
    if (ptr !== 6'd0 || tout !== 64'hF000_0000_0000_003F) begin errors++; $display("FAIL clr_alone got=%0d/%h exp=0/%h", ptr, tout, 64'hF000_0000_0000_003F); end
    apply(1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 6'd9, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 6'd3, 1'b1, 1'b1);
    checks++;
    if (tout !== 64'h7 || ptr !== 6'd3 || tout_vld !== 1'b1) begin errors++; $display("FAIL clr_with_sample got=%h/%0d exp=7/3", tout, ptr); end
  endtask

  task automatic test_boundary();
    apply(1'b0, 1'b1, 6'd63, 1'b1, 1'b0);
    checks++;
    if (tout !== 64'hFFFF_FFFF_FFFF_FFFB || ptr !== 6'd2) begin errors++; $display("FAIL max_code got=%h/%0d exp=%h/2", tout, ptr, 64'hFFFF_FFFF_FFFF_FFFB); end
    apply(1'b0, 1'b1, 6'd0, 1'b1, 1'b0);
    checks++;
    if (tout !== 64'h0 || ptr !== 6'd2 || tout_vld !== 1'b1) begin errors++; $display("FAIL zero_code got=%h/%0d/%b exp=0/2/1", tout, ptr, tout_vld); end
    apply(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
    checks++;
    if (tout !== 64'h1F || ptr !== 6'd5) begin errors++; $display("FAIL dwa_off got=%h/%0d exp=1f/5", tout, ptr); end
    apply(1'b0, 1'b1, 6'd4, 1'b1, 1'b0);
    checks++;
    if (tout !== 64'h1E0 || ptr !== 6'd9) begin errors++; $display("FAIL dwa_back_on got=%h/%0d exp=1e0/9", tout, ptr); end
  endtask

  task automatic test_random();
    logic [63:0] exp_tout;
    logic [5:0]  exp_ptr;
    logic [5:0]  s;
    logic        v, en, clr;
    logic [5:0]  d;
    apply(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    exp_tout = '0;
    exp_ptr  = '0;
    for (int n = 0; n < 10000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      en  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 7) == 0);
      d   = 6'($urandom_range(0, 63));
      s   = (en && !clr) ? exp_ptr : 6'd0;
      if (v) begin
        exp_tout = '0;
        for (int k = 0; k < int'(d); k++) exp_tout[(int'(s) + k) % 64] = 1'b1;
        exp_ptr = s + d;
      end else if (clr) begin
        exp_ptr = '0;
      end
      apply(1'b0, v, d, en, clr);
      checks++;
      if (tout !== exp_tout || tout_vld !== v || ptr !== exp_ptr) begin
        errors++;
        $display("FAIL random n=%0d din=%0d s=%0d got=%h/%b/%0d exp=%h/%b/%0d",
                 n, d, s, tout, tout_vld, ptr, exp_tout, v, exp_ptr);
      end
      if (v) begin
        checks++;
        if ($countones(tout) != int'(d)) begin errors++; $display("FAIL random_popcount n=%0d got=%0d exp=%0d", n, $countones(tout), d); end
      end
    end
  endtask

  task automatic test_midstream_reset();
    apply(1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 6'd45, 1'b1, 1'b0);
    checks++;
    if (ptr !== 6'd45) begin errors++; $display("FAIL pre_reset_ptr got=%0d exp=45", ptr); end
    apply(1'b1, 1'b1, 6'd7, 1'b1, 1'b0);
    checks++;
    if (tout !== 64'h0 || ptr !== 6'd0 || tout_vld !== 1'b0) begin errors++; $display("FAIL midstream_reset got=%h/%0d/%b exp=0/0/0", tout, ptr, tout_vld); end
    apply(1'b0, 1'b1, 6'd7, 1'b1, 1'b0);
    checks++;
    if (tout !== 64'h7F || ptr !== 6'd7) begin errors++; $display("FAIL post_reset got=%h/%0d exp=7f/7", tout, ptr); end
  endtask

  initial begin
    rst = 1'b1; din = '0; din_vld = 1'b0; dwa_en = 1'b0; ptr_clr = 1'b0;
    test_reset();
    test_plain();
    test_dwa_wrap();
    test_hold_clear();
    test_boundary();
    test_random();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/therm_dwa_dec.md
Name: therm_dwa_dec

Overview:
- Binary-to-thermometer decoder with data-weighted-averaging (DWA) element rotation, for the 64-element unary DAC.
- It is the reverse of the 64-input thermometer-to-6-bit fat-tree encoder used on the ADC side.
- Accepts a 6-bit code per valid cycle and drives a registered 64-bit element-select word with exactly `code` bits set.
- The set bits are rotated by a running pointer so element usage is averaged across codes.

Parameters:
- N_BITS, 6, code width; element count N_ELEM = 2**N_BITS (64 at default).
- PTR_RST, 0, pointer value loaded at reset; range 0..N_ELEM-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din  input  N_BITS  binary code, range 0..N_ELEM-1.
- din_vld  input  1  din is valid this cycle; sampled at the clk edge.
- dwa_en  input  1  1 = rotate by the pointer; 0 = plain thermometer (pointer forced to 0).
- ptr_clr  input  1  synchronous pointer clear.
- tout  output  N_ELEM  element-select word; bit i = 1 enables DAC element i.
- tout_vld  output  1  pulses 1 the cycle after an accepted din.
- ptr  output  N_BITS  current DWA pointer (the start element for the next sample).

Behaviour:
- Reset, synchronous with rst=1 at a clk edge:
  - tout = 0, tout_vld = 0, ptr = PTR_RST.
  - rst overrides every other input, including a reset asserted mid-stream.
  - The first sample after rst deasserts is handled normally.
- Effective start pointer for a sample, s:
  - s = 0 if dwa_en=0 or ptr_clr=1.
  - Otherwise s = ptr.
- Accepted sample (din_vld=1, rst=0), registered with latency 1 cycle:
  - tout[(s+k) mod N_ELEM] = 1 for k = 0..din-1; all other bits 0.
  - Popcount(tout) equals din exactly.
  - tout_vld = 1.
  - Next ptr = (s + din) mod N_ELEM. Use N_BITS-bit modular addition; wrap-around is natural overflow.
- din_vld=0 cycle:
  - tout holds its previous value (the DAC must not glitch to zero).
  - tout_vld = 0.
  - ptr holds, except ptr_clr=1 sets ptr = 0.
- din = 0 accepted: tout = all zeros, ptr unchanged (= s), tout_vld = 1.
- Wrap: if s + din > N_ELEM-1, the set bits run from s up to bit N_ELEM-1, then continue from bit 0. The run is contiguous modulo N_ELEM.
- dwa_en=0:
  - tout = din ones packed from bit 0 (standard thermometer); ptr ends at din.
  - Each sample restarts from 0.
  - Switching dwa_en takes effect on the next accepted sample; there is no history.
- ptr_clr with din_vld=1 in the same cycle: the sample uses s = 0, and ptr = din afterwards. The clear has priority over the old pointer, but the update still applies.
- Maximum code N_ELEM-1 (63): exactly one element is off, namely element (s+63) mod 64 = (s-1) mod 64. ptr = (s-1) mod 64.
- Full throughput: din_vld may be 1 every cycle; no backpressure, no stall path.
- Implementation:
  - The thermometer mask is generated from din, then rotated left by s using a barrel rotator (N_BITS stages).
  - No combinational path from input to output; tout, tout_vld and ptr are flops.
- Round trip: with dwa_en=0, feeding tout back through the 64-to-6 thermometer encoder must return din.

Test Plan:
- Reset: hold rst 3 cycles with din_vld=1, din=20 -> tout=0, tout_vld=0, ptr=0 throughout. The first sample after release decodes normally.
- Plain thermometer: dwa_en=0, apply din=0, 1, 32, 63 on consecutive cycles. One cycle later each gives tout = 0, 0x1, 0x0000_0000_FFFF_FFFF, 0x7FFF_FFFF_FFFF_FFFF respectively, with tout_vld=1 each cycle.
- DWA sequence and wrap: dwa_en=1, from reset apply din=10, then 50, then 10.
  - tout = 0x3FF, ptr=10.
  - Then bits 10..59 set, ptr=60.
  - Then bits 60..63 and 0..5 set (0xF000_0000_0000_003F), ptr=6.
- Hold and clear:
  - After the DWA sequence, drop din_vld for 4 cycles -> tout stays 0xF000_0000_0000_003F, tout_vld=0, ptr=6.
  - Pulse ptr_clr alone -> ptr=0.
  - Then ptr_clr=1 with din_vld=1, din=3 -> tout=0x7, ptr=3.
- Random self-check: 10k random din with random din_vld/dwa_en/ptr_clr; the bench models ptr. Required each accepted sample:
  - popcount(tout) = din.
  - The set bits form one contiguous run modulo 64 starting at s.
  - ptr = (s+din) mod 64.
- Mid-stream reset: assert rst while ptr=45 and din_vld=1 -> next edge gives tout=0, ptr=0, tout_vld=0.
